// File: rtl/mini16_rr_arbiter_if.sv
// Requester bank and shared write port of the round-robin arbiter.
interface mini16_rr_arbiter_if #(
   parameter int REQ_N    = 8,
   parameter int WIDTH_A  = 13,
   parameter int WIDTH_D  = 16,
   parameter int WIDTH_ID = $clog2(REQ_N)
);
   logic [REQ_N-1:0]         req_valid;
   logic [REQ_N*WIDTH_A-1:0] req_addr;
   logic [REQ_N*WIDTH_D-1:0] req_data;
   logic [REQ_N-1:0]         req_ready;
   logic                     out_valid;
   logic [WIDTH_A-1:0]       out_addr;
   logic [WIDTH_D-1:0]       out_data;
   logic [WIDTH_ID-1:0]      out_id;
   logic                     out_ready;

   modport slave (
      input  req_valid, req_addr, req_data, out_ready,
      output req_ready, out_valid, out_addr, out_data, out_id
   );

   modport master (
      output req_valid, req_addr, req_data, out_ready,
      input  req_ready, out_valid, out_addr, out_data, out_id
   );
endinterface

// File: rtl/mini16_rr_arbiter.sv
// Round-robin arbiter: REQ_N requesters share one registered write slot.
module mini16_rr_arbiter #(
   parameter int REQ_N    = 8,
   parameter int WIDTH_A  = 13,
   parameter int WIDTH_D  = 16,
   parameter int WIDTH_ID = $clog2(REQ_N)
) (
   input  logic               clk,
   input  logic               reset,
   mini16_rr_arbiter_if.slave bus
);
   // one spare bit so last_grant + offset never overflows before wrap
   localparam int SW = WIDTH_ID + 1;

   logic                slot_valid;
   logic [WIDTH_A-1:0]  slot_addr;
   logic [WIDTH_D-1:0]  slot_data;
   logic [WIDTH_ID-1:0] slot_id;
   logic [WIDTH_ID-1:0] last_grant;

   logic                load_en;
   logic                found;
   logic [WIDTH_ID-1:0] winner;
   logic [SW-1:0]       cand;
   logic [REQ_N-1:0]    ready;

   assign load_en = !slot_valid || bus.out_ready;

   always_comb begin
      winner = last_grant;
      found  = 1'b0;
      cand   = '0;
      for (int k = 1; k <= REQ_N; k++) begin
         cand = SW'(last_grant) + SW'(k);
         if (cand >= SW'(REQ_N)) begin
            cand = cand - SW'(REQ_N);
         end
         if (!found && bus.req_valid[cand[WIDTH_ID-1:0]]) begin
            found  = 1'b1;
            winner = cand[WIDTH_ID-1:0];
         end
      end
   end

   always_comb begin
      ready = '0;
      if (load_en && found && !reset) begin
         ready[winner] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         slot_valid <= 1'b0;
         slot_addr  <= '0;
         slot_data  <= '0;
         slot_id    <= '0;
         last_grant <= WIDTH_ID'(REQ_N - 1);
      end else if (load_en) begin
         slot_valid <= found;
         if (found) begin
            slot_addr  <= bus.req_addr[int'(winner)*WIDTH_A +: WIDTH_A];
            slot_data  <= bus.req_data[int'(winner)*WIDTH_D +: WIDTH_D];
            slot_id    <= winner;
            last_grant <= winner;
         end
      end
   end

   assign bus.req_ready = ready;
   assign bus.out_valid = slot_valid;
   assign bus.out_addr  = slot_addr;
   assign bus.out_data  = slot_data;
   assign bus.out_id    = slot_id;
endmodule

// File: doc/mini16_rr_arbiter.md
MINI16_RR_ARBITER -- requirements
Module: mini16_rr_arbiter

Interface
REQ-001 Parameter REQ_N, default 8, number of requesting PEs (2..64).
REQ-002 Parameter WIDTH_A, default 13, request address width.
REQ-003 Parameter WIDTH_D, default 16, request data width.
REQ-004 Parameter WIDTH_ID, default $clog2(REQ_N), granted-requester index width.
REQ-005 clk  input  1  single clock; all logic on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 req_valid  input  REQ_N  per-requester request pending; bit i belongs to PE i.
REQ-008 req_addr  input  REQ_N*WIDTH_A  packed addresses; PE i at [i*WIDTH_A +: WIDTH_A].
REQ-009 req_data  input  REQ_N*WIDTH_D  packed data; PE i at [i*WIDTH_D +: WIDTH_D].
REQ-010 req_ready  output  REQ_N  one-hot-or-zero accept strobe; request i is consumed in a cycle where req_valid[i] && req_ready[i].
REQ-011 out_valid  output  1  shared write port holds a valid transfer.
REQ-012 out_addr  output  WIDTH_A  address of held transfer.
REQ-013 out_data  output  WIDTH_D  data of held transfer.
REQ-014 out_id  output  WIDTH_ID  index of PE that issued held transfer.
REQ-015 out_ready  input  1  downstream accepts; transfer completes when out_valid && out_ready.

Function
REQ-016 The block SHALL hold exactly one output register slot (out_valid/out_addr/out_data/out_id).
REQ-017 load_en SHALL be (!out_valid || out_ready), evaluated combinationally each cycle.
REQ-018 A register last_grant (WIDTH_ID bits) SHALL record the index of the most recently granted PE.
REQ-019 Priority order SHALL be last_grant+1, last_grant+2, ..., last_grant, all modulo REQ_N (wrap from REQ_N-1 to 0).
REQ-020 winner SHALL be the first index in priority order with req_valid set; no winner when req_valid is all zero.
REQ-021 req_ready SHALL have only bit winner set when load_en and a winner exists, else all zero; at most one bit ever set.
REQ-022 On a cycle with load_en and a winner, the output register SHALL capture the winner's addr/data/index with out_valid=1, and last_grant SHALL update to winner, visible next cycle.
REQ-023 On a cycle with load_en and no winner, out_valid SHALL go 0 next cycle; last_grant and out_addr/out_data/out_id SHALL hold.
REQ-024 When !load_en (out_valid=1, out_ready=0), out_* and last_grant SHALL hold stable and req_ready SHALL be zero.
REQ-025 Simultaneous drain and refill (out_valid && out_ready with a winner) SHALL complete the old transfer and load the new one in the same cycle: sustained throughput one transfer per clock.
REQ-026 Latency from accept (req_valid[i] && req_ready[i]) to out_valid with that payload SHALL be exactly 1 cycle.
REQ-027 With all REQ_N requesters continuously valid and out_ready=1, grants SHALL cycle strictly i, i+1, ..., wrapping; any requester waits at most REQ_N-1 grants.
REQ-028 A requester SHALL hold req_valid/addr/data stable until accepted; the arbiter relies on this and has no input buffering.
REQ-029 A req_valid bit dropping before acceptance SHALL simply remove that PE from arbitration in that cycle (no error).
REQ-030 For REQ_N not a power of two, indices >= REQ_N SHALL never be granted and wrap SHALL be at REQ_N-1.

Reset
REQ-031 While reset=1 at a clock edge: out_valid<=0, out_addr<=0, out_data<=0, out_id<=0, last_grant<=REQ_N-1 (so PE 0 has top priority first).
REQ-032 req_ready SHALL be all zero in any cycle where reset=1; a transfer pending in the slot at reset SHALL be discarded, not delivered.
REQ-033 The first cycle after reset deasserts SHALL accept requests normally.

Verification
REQ-034 Reset, then req_valid=8'hFF, out_ready=1 for 10 cycles -> out_id sequence 0,1,2,3,4,5,6,7,0,1; req_ready one-hot each cycle.
REQ-035 req_valid=8'b0010_0100, last_grant=2, out_ready=1 -> grants 5, then 2, then 5; PE 2 accept cycle with addr 0x0123 data 0xBEEF -> next cycle out_addr=0x0123, out_data=0xBEEF, out_id=2.
REQ-036 out_valid=1, out_ready=0 for 4 cycles with all PEs requesting -> req_ready=0 and out_* unchanged all 4 cycles; out_ready=1 -> next grant is last_grant+1.
REQ-037 Single PE 7 requesting continuously, out_ready toggling 1/0 each cycle -> PE 7 accepted every cycle out_ready=1 or slot empty; no transfer lost or duplicated (scoreboard).
REQ-038 Assert reset while out_valid=1 and out_ready=0 -> next cycle out_valid=0, last_grant=7; held transfer never appears with out_ready.
REQ-039 REQ_N=5 all valid -> grants 0,1,2,3,4,0; out_id never exceeds 4.
